// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding valid/ready word store with fixed, programmable response latency
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (array contents are kept)
//   req_valid  : request offered          req_ready : responder idle, can accept
//   req_write  : 1 = write, 0 = read      req_addr  : byte address
//   req_wdata  : write data
//   resp_valid : response available       resp_ready: initiator consumes response
//   resp_rdata : read data (0 for writes and errors)
//   resp_err   : request misaligned or out of range
module data_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d, err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     off;
  logic            go, commit;
  // The *_d request fields equal the live request on the accept edge and the
  // latched one afterwards, so they also serve as the commit-edge operands
  // (with LATENCY==1 the commit edge is the accept edge).
  always_comb begin
    off          = req_addr - BASE_ADDR;
    go           = (state_q == IDLE) && req_valid && req_ready_q;
    wr_d         = go ? req_write : wr_q;
    wdata_d      = go ? req_wdata : wdata_q;
    idx_d        = go ? off[AW+1:2] : idx_q;
    err_d        = go ? ((req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH))) : err_q;
    commit       = (go && LATENCY == 1) || (state_q == WAIT && cnt_q == CW'(1));
    cnt_d        = go ? CW'(LATENCY - 1) : (state_q == WAIT) ? cnt_q - CW'(1) : cnt_q;
    state_d      = go ? (LATENCY == 1 ? RESP : WAIT) :
                   commit ? RESP :
                   (state_q == RESP) ? (resp_ready ? IDLE : RESP) :
                   (state_q == WAIT) ? WAIT : IDLE;
    resp_rdata_d = commit ? ((wr_d || err_d) ? 32'h0 : mem[idx_d]) : resp_rdata_q;
    resp_err_d   = commit ? err_d : resp_err_q;
    req_ready_d  = state_d == IDLE;
    resp_valid_d = state_d == RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  // No reset on the array: contents survive rst, and a write discarded by rst
  // never reaches its commit edge because state_q is forced to IDLE.
  always_ff @(posedge clk)
    if (commit && wr_d && !err_d) mem[idx_d] <= wdata_d;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_data_mem_responder;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 1'b0, rst, sel;
  logic req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic r0_req_ready, r0_resp_valid, r0_resp_err, r1_req_ready, r1_resp_valid, r1_resp_err;
  logic [31:0] r0_resp_rdata, r1_resp_rdata;
  exp_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, prev_acc = 0;
  logic prev_valid = 1'b0;
  data_mem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r0_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r0_resp_valid), .resp_ready(resp_ready), .resp_rdata(r0_resp_rdata), .resp_err(r0_resp_err));
  data_mem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r1_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(r1_resp_valid), .resp_ready(resp_ready), .resp_rdata(r1_resp_rdata), .resp_err(r1_resp_err));
  assign req_ready  = sel ? r1_req_ready  : r0_req_ready;
  assign resp_valid = sel ? r1_resp_valid : r0_resp_valid;
  assign resp_rdata = sel ? r1_resp_rdata : r0_resp_rdata;
  assign resp_err   = sel ? r1_resp_err   : r0_resp_err;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endtask
  // Monitor: samples 1 time unit after the falling edge, so stimulus driven on
  // that edge is already visible and the next rising edge is still ahead.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (resp_valid && !prev_valid) chk("latency", 32'(cyc + 1 - acc_cyc), sel ? 32'd1 : 32'd2);
    prev_valid = resp_valid;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end
  // Called on a falling edge; returns on the falling edge after the accept edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] er, input logic ee);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    else begin
      exp_q.push_back('{rdata: er, err: ee});
      prev_acc = acc_cyc;
      acc_cyc = cyc + 1;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (!resp_valid) chk("valid_timeout", 32'(resp_valid), 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    #7;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(req_ready), 32'd1);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
    issue(1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 32'h1000, 32'h11111111, 32'h0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);
    issue(1'b1, 32'hFFC, 32'hCAFE0001, 32'h0, 1'b0);
    issue(1'b0, 32'hFFC, 32'h0, 32'hCAFE0001, 1'b0);
    issue(1'b0, 32'h1002, 32'h0, 32'h0, 1'b1);
    wait_empty();
    resp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_valid();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    wait_empty();
    issue(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    issue(1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
    wait_empty();
    issue(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    chk("wait_rst_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    issue(1'b0, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);
    wait_empty();
    resp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);
    wait_valid();
    #2 rst = 1'b1;
    #1;
    chk("pulse_req_ready", 32'(req_ready), 32'd0);
    chk("pulse_resp_valid", 32'(resp_valid), 32'd0);
    chk("pulse_resp_rdata", resp_rdata, 32'd0);
    chk("pulse_resp_err", 32'(resp_err), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("pulse_ready_after_release", 32'(req_ready), 32'd1);
    sel = 1'b1;
    issue(1'b1, 32'h0, 32'h00000011, 32'h0, 1'b0);
    issue(1'b1, 32'h4, 32'h00000022, 32'h0, 1'b0);
    chk("b2b_spacing_1", 32'(acc_cyc - prev_acc), 32'd2);
    issue(1'b1, 32'h8, 32'h00000033, 32'h0, 1'b0);
    chk("b2b_spacing_2", 32'(acc_cyc - prev_acc), 32'd2);
    issue(1'b0, 32'h0, 32'h0, 32'h00000011, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 32'h00000022, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 32'h00000033, 1'b0);
    issue(1'b1, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 32'h00000011, 1'b0);
    issue(1'b0, 32'h3E, 32'h0, 32'h0, 1'b1);
    wait_empty();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
